flop_fifo_out: RTL and testbench

- Pop-side counterpart of the input-flopped FIFO: a circular-buffer FIFO whose read data is always driven from a dedicated output register, with no combinational path from storage to the output.
- Upstream pushes without a handshake, guarded by full/watermark.
- Downstream drains through a valid/ready handshake.
- Placed at block egress, where timing toward the consumer is critical.

---
 rtl/flop_fifo_pkg.sv | 15 +
 rtl/flop_fifo_out_if.sv | 29 ++
 rtl/flop_fifo_out_ptr.sv | 33 +++
 rtl/flop_fifo_out.sv | 169 ++++++++++++++++
 tb/tb_flop_fifo_out.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/flop_fifo_pkg.sv
// Shared types and constants for the output-flopped FIFO.
package flop_fifo_pkg;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam logic [15:0] STALL_TIMEOUT = 16'hFFFF;

    typedef struct packed {
        logic ovf;
        logic stall;
    } err_flags_t;

endpackage

// File: rtl/flop_fifo_out_if.sv
// Push/pop bus of the output-flopped FIFO; slave is the FIFO, master is the environment.
interface flop_fifo_out_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
);
    import flop_fifo_pkg::*;

    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             full;
    logic             watermark;
    logic [CNT_W-1:0] count;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output push, push_data, out_ready,
        input  full, watermark, count, out_valid, out_data
    );

    modport slave (
        input  push, push_data, out_ready,
        output full, watermark, count, out_valid, out_data
    );

endinterface

// File: rtl/flop_fifo_out_ptr.sv
// Wrapping pointer over N entries with synchronous clear and increment enable.
module flop_fifo_out_ptr #(
    parameter  int unsigned N = 3,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_d;

    // With N == 1 the wrap compare always matches, so the pointer stays 0.
    always_comb begin
        ptr_d = ptr;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr == W'(N - 1)) ? '0 : ptr + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_d;
        end
    end

endmodule

// File: rtl/flop_fifo_out.sv
// Circular-buffer FIFO whose read side is always driven from a dedicated output register.
// Define FLOP_FIFO_OUT_ERR_CHK_EN to add sticky err_ovf/err_stall flags and an occupancy assertion.
module flop_fifo_out
    import flop_fifo_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sync_rst_n,
    input  logic [31:0] cfg_watermark,
    flop_fifo_out_if.slave bus
`ifdef FLOP_FIFO_OUT_ERR_CHK_EN
    ,
    output logic        err_ovf,
    output logic        err_stall
`endif
);

    localparam int unsigned ENTRIES = DEPTH - 1;
    localparam int unsigned AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [WIDTH-1:0] mem [ENTRIES];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             full_q,      full_d;

    logic             acc_push;
    logic             pop;
    logic             load_en;
    logic             arr_empty;
    logic             take_arr;
    logic             bypass;
    logic             wr_en;
    logic [CNT_W-1:0] arr_cnt;
    logic             unused_cfg_bits;

    assign acc_push  = bus.push & ~full_q;
    assign pop       = out_valid_q & bus.out_ready;
    assign arr_cnt   = count_q - CNT_W'(out_valid_q);
    assign arr_empty = (arr_cnt == '0);
    assign load_en   = ~out_valid_q | pop;
    assign take_arr  = sync_rst_n & load_en & ~arr_empty;
    // Bypass only when nothing is queued ahead of the new word.
    assign bypass    = load_en & arr_empty & acc_push;
    assign wr_en     = sync_rst_n & acc_push & ~bypass;

    assign unused_cfg_bits = ^cfg_watermark[31:CNT_W];

    flop_fifo_out_ptr #(.N(ENTRIES)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~sync_rst_n),
        .inc   (wr_en),
        .ptr   (wr_ptr)
    );

    flop_fifo_out_ptr #(.N(ENTRIES)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~sync_rst_n),
        .inc   (take_arr),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.push_data;
        end
    end

    // Next state for the output register and occupancy.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        count_d     = count_q;
        full_d      = full_q;
        if (!sync_rst_n) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            count_d     = '0;
            full_d      = 1'b0;
        end else begin
            count_d = count_q + CNT_W'(acc_push) - CNT_W'(pop);
            full_d  = (count_d == CNT_W'(DEPTH));
            if (load_en) begin
                if (!arr_empty) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem[rd_ptr];
                end else if (acc_push) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.push_data;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            count_q     <= count_d;
            full_q      <= full_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.watermark = (count_q >= cfg_watermark[CNT_W-1:0]);

`ifdef FLOP_FIFO_OUT_ERR_CHK_EN
    err_flags_t  err_q, err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stalled;

    assign stalled = out_valid_q & ~bus.out_ready;

    // Sticky error flags; stall counter saturates at the timeout.
    always_comb begin
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q;
        if (!sync_rst_n) begin
            err_d       = '0;
            stall_cnt_d = '0;
        end else begin
            err_d.ovf = err_q.ovf | (bus.push & full_q);
            if (stalled) begin
                err_d.stall = err_q.stall | (stall_cnt_q == STALL_TIMEOUT);
                if (stall_cnt_q != STALL_TIMEOUT) begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
            end else begin
                stall_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign err_ovf   = err_q.ovf;
    assign err_stall = err_q.stall;

    a_count_max: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_W'(DEPTH));
`endif

endmodule

// File: tb/tb_flop_fifo_out.sv
// Scoreboard bench for flop_fifo_out: driver queues expected words, negedge monitor checks.
module tb_flop_fifo_out;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        sync_rst_n = 1'b1;
    logic [31:0] wm         = 32'd0;

    always #5 clk = ~clk;

    flop_fifo_out_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef FLOP_FIFO_OUT_ERR_CHK_EN
    logic err_ovf;
    logic err_stall;
`endif

    flop_fifo_out #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sync_rst_n    (sync_rst_n),
        .cfg_watermark (wm),
        .bus           (bus)
`ifdef FLOP_FIFO_OUT_ERR_CHK_EN
        ,
        .err_ovf       (err_ovf),
        .err_stall     (err_stall)
`endif
    );

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];
    int               cur_cnt  = 0;
    int               nxt_cnt  = 0;
    bit               skip_pop = 1'b0;
    bit               flush    = 1'b0;
    bit               done     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: occupancy flags every cycle, data on every handshake.
    always @(negedge clk) begin
        if (!done) begin
            check("count", 64'(bus.count), 64'(cur_cnt));
            check("full", 64'(bus.full), 64'(cur_cnt == DEPTH));
            check("out_valid", 64'(bus.out_valid), 64'(cur_cnt > 0));
            check("watermark", 64'(bus.watermark), 64'(cur_cnt >= int'(wm[CNT_W-1:0])));
            if (bus.out_valid && bus.out_ready && !skip_pop) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_underflow: got %0h expected no data at %0t", bus.out_data, $time);
                end else begin
                    check("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step(input bit p, input logic [WIDTH-1:0] d, input bit r, input bit srst = 1'b0);
        int acc;
        int popm;
        @(posedge clk);
        #1;
        if (flush) begin
            exp_q.delete();
            flush = 1'b0;
        end
        cur_cnt       = nxt_cnt;
        skip_pop      = srst;
        bus.push      = p;
        bus.push_data = d;
        bus.out_ready = r;
        sync_rst_n    = ~srst;
        if (srst) begin
            nxt_cnt = 0;
            flush   = 1'b1;
        end else begin
            acc  = (p && cur_cnt < int'(DEPTH)) ? 1 : 0;
            popm = (r && cur_cnt > 0) ? 1 : 0;
            if (acc != 0) exp_q.push_back(d);
            nxt_cnt = cur_cnt + acc - popm;
        end
    endtask

    task automatic async_reset(input logic [WIDTH-1:0] d);
        @(posedge clk);
        #1;
        if (flush) begin
            exp_q.delete();
            flush = 1'b0;
        end
        cur_cnt       = nxt_cnt;
        skip_pop      = 1'b0;
        sync_rst_n    = 1'b1;
        bus.push      = 1'b1;
        bus.push_data = d;
        bus.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        cur_cnt = 0;
        nxt_cnt = 0;
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        bus.push = 1'b0;
    endtask

    initial begin
        int pp;
        int rp;
        bus.push      = 1'b0;
        bus.push_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Empty bypass
        step(1'b1, 32'hA5, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);

        // Fill, drop on full, hold under backpressure, drain back-to-back
        for (int i = 1; i <= 4; i++) step(1'b1, WIDTH'(i), 1'b0);
        step(1'b1, 32'h55, 1'b0);
        repeat (10) step(1'b0, 32'h0, 1'b0);
        repeat (5) step(1'b0, 32'h0, 1'b1);

        // Steady stream
        repeat (100) step(1'b1, $urandom, 1'b1);
        repeat (2) step(1'b0, 32'h0, 1'b1);

        // Watermark at 2
        wm = 32'd2;
        repeat (2) step(1'b1, $urandom, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        repeat (2) step(1'b0, 32'h0, 1'b1);

        // Synchronous clear with a colliding push
        for (int i = 0; i < 3; i++) step(1'b1, 32'h100 + WIDTH'(i), 1'b0);
        step(1'b1, 32'hDEAD, 1'b0, 1'b1);
        repeat (2) step(1'b0, 32'h0, 1'b0);

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + WIDTH'(i), 1'b0);
        async_reset(32'hBEEF);
        repeat (2) step(1'b0, 32'h0, 1'b1);

        // Randomized phases of push/ready density
        for (int ph = 0; ph < 12; ph++) begin
            pp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            wm = 32'($urandom_range(0, 7));
            for (int c = 0; c < 250; c++) begin
                step($urandom_range(0, 99) < pp, $urandom, $urandom_range(0, 99) < rp,
                     $urandom_range(0, 199) == 0);
            end
        end

        repeat (DEPTH + 2) step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("drained", 64'(exp_q.size()), 64'd0);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
